// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern engine and its register port.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_PWM    = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } scan_dir_t;

  localparam logic [1:0] ADDR_MODE    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_DUTY    = 2'd3;

  localparam int PERIOD_W = 16;

  // A period of zero ticks has no meaning, so it is stored as one tick.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] value);
    return (value == '0) ? PERIOD_W'(1) : value;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: tick is high for one clk out of every TICK_DIV.
module led_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: static, blink, bounce-scan and PWM-dim modes over NUM_LED
// outputs, configured through a four-register write port and paced by a shared tick.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LED  = 4,
  parameter int TICK_DIV = 100000,
  parameter int PWM_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic               cfg_ack,
  output logic               tick,
  output logic [NUM_LED-1:0] led
);

  localparam int POS_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LED - 1);

  led_mode_t             mode_q;
  logic [NUM_LED-1:0]    pattern_q;
  logic [PERIOD_W-1:0]   period_q;
  logic [PWM_BITS-1:0]   duty_q;

  logic [PERIOD_W-1:0]   tcnt_q, tcnt_d;
  logic                  phase_q, phase_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  scan_dir_t             dir_q, dir_d;
  logic [PWM_BITS-1:0]   pwm_q;
  logic [NUM_LED-1:0]    led_d;
  logic                  restart;
  logic                  step;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign restart = cfg_we && ((cfg_addr == ADDR_MODE) || (cfg_addr == ADDR_PERIOD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_STATIC;
      pattern_q <= '0;
      period_q  <= PERIOD_W'(1);
      duty_q    <= '0;
      cfg_ack   <= 1'b0;
    end else begin
      cfg_ack <= cfg_we;
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_MODE:    mode_q    <= led_mode_t'(cfg_wdata[1:0]);
          ADDR_PATTERN: pattern_q <= NUM_LED'(cfg_wdata);
          ADDR_PERIOD:  period_q  <= clamp_period(cfg_wdata);
          ADDR_DUTY:    duty_q    <= PWM_BITS'(cfg_wdata);
          default:      ;
        endcase
      end
    end
  end

  // A restart beats a coincident tick, so that tick never reaches the counter.
  always_comb begin
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step    = 1'b0;

    if (restart) begin
      tcnt_d  = '0;
      phase_d = 1'b1;
      pos_d   = '0;
      dir_d   = DIR_UP;
    end else if (tick) begin
      if (tcnt_q == period_q - 1'b1) begin
        tcnt_d = '0;
        step   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end

    if (step) begin
      phase_d = ~phase_q;
      if (NUM_LED > 1) begin
        if (dir_q == DIR_UP) begin
          if (pos_q == POS_LAST) begin
            pos_d = pos_q - 1'b1;
            dir_d = DIR_DOWN;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          if (pos_q == '0) begin
            pos_d = pos_q + 1'b1;
            dir_d = DIR_UP;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_STATIC: led_d = pattern_q;
      MODE_BLINK:  led_d = phase_q ? pattern_q : '0;
      MODE_SCAN:   led_d = NUM_LED'(1) << pos_q;
      MODE_PWM:    led_d = (pwm_q < duty_q) ? pattern_q : '0;
      default:     led_d = '0;
    endcase
  end

  // The PWM counter free-runs in every mode; it is never restarted by writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      phase_q <= 1'b1;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      pwm_q   <= '0;
      led     <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_q + 1'b1;
      led     <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: a directed table, hand-written multi-cycle sequences and
// random register traffic, all compared every cycle with a tick/event-count reference model.
module tb_led_pattern_ctrl;
  import led_ctrl_pkg::*;

  localparam int NL = 4;
  localparam int TD = 4;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [15:0]   cfg_wdata;
  logic          cfg_ack;
  logic          tick;
  logic [NL-1:0] led;

  int errors = 0;
  int checks = 0;

  // Reference model: edges since reset, ticks since last restart, and register copies.
  int unsigned   mj;
  int unsigned   mticks;
  int unsigned   mmode;
  logic [NL-1:0] mpat;
  int unsigned   mper;
  int unsigned   mduty;
  logic [NL-1:0] mled;
  logic          mack;
  logic          mtick;

  logic [NL-1:0] rv[$];
  int            rl[$];

  typedef struct {
    logic [15:0]   data;
    logic [NL-1:0] exp_led;
  } static_vec_t;

  static_vec_t svec[5];

  led_pattern_ctrl #(
    .NUM_LED (NL),
    .TICK_DIV(TD),
    .PWM_BITS(PB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_ack  (cfg_ack),
    .tick     (tick),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got=%0h expected=%0h", name, mj, got, exp);
    end
  endtask

  task automatic modelReset();
    mj     = 0;
    mticks = 0;
    mmode  = 0;
    mpat   = '0;
    mper   = 1;
    mduty  = 0;
    mled   = '0;
    mack   = 1'b0;
    mtick  = 1'b0;
  endtask

  // Blink phase and scan position follow from how many full periods have elapsed.
  function automatic logic [NL-1:0] modelLed();
    int unsigned ev;
    int unsigned p;
    ev = mticks / mper;
    case (mmode)
      0: return mpat;
      1: return (ev % 2 == 0) ? mpat : '0;
      2: begin
        p = ev % (2 * (NL - 1));
        if (p >= NL) p = 2 * (NL - 1) - p;
        return NL'(1) << p;
      end
      default: return ((mj % (1 << PB)) < mduty) ? mpat : '0;
    endcase
  endfunction

  task automatic modelStep(input logic we, input logic [1:0] addr, input logic [15:0] data);
    bit rst_eng;
    mled = modelLed();
    mack = we;
    mj++;
    rst_eng = we && (addr == ADDR_MODE || addr == ADDR_PERIOD);
    if (we) begin
      case (addr)
        ADDR_MODE:    mmode = data % 4;
        ADDR_PATTERN: mpat  = data[NL-1:0];
        ADDR_PERIOD:  mper  = (data == 0) ? 1 : data;
        default:      mduty = data % (1 << PB);
      endcase
    end
    if (rst_eng) mticks = 0;
    else if (mj % TD == 0) mticks++;
    mtick = (mj % TD == TD - 1);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [15:0] data);
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    modelStep(we, addr, data);
    checkOutput("led", led, mled);
    checkOutput("tick", tick, mtick);
    checkOutput("cfg_ack", cfg_ack, mack);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 16'd0);
  endtask

  task automatic observeRuns(input int n);
    logic [NL-1:0] cur;
    int len;
    rv.delete();
    rl.delete();
    idle(1);
    cur = led;
    len = 1;
    for (int i = 1; i < n; i++) begin
      idle(1);
      if (led == cur) len++;
      else begin
        rv.push_back(cur);
        rl.push_back(len);
        cur = led;
        len = 1;
      end
    end
    rv.push_back(cur);
    rl.push_back(len);
  endtask

  initial begin
    int hi;
    int lo;
    int upper;
    bit found;
    bit all_on;
    logic [NL-1:0] scan_exp[8];

    svec[0] = '{16'h000A, 4'b1010};
    svec[1] = '{16'hFFF5, 4'b0101};
    svec[2] = '{16'h0003, 4'b0011};
    svec[3] = '{16'h1230, 4'b0000};
    svec[4] = '{16'h800F, 4'b1111};

    scan_exp[0] = 4'b0001; scan_exp[1] = 4'b0010; scan_exp[2] = 4'b0100; scan_exp[3] = 4'b1000;
    scan_exp[4] = 4'b0100; scan_exp[5] = 4'b0010; scan_exp[6] = 4'b0001; scan_exp[7] = 4'b0010;

    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 16'd0;
    modelReset();
    #12;
    checkOutput("reset_led", led, 0);
    checkOutput("reset_ack", cfg_ack, 0);
    checkOutput("reset_tick", tick, 0);
    reset = 1'b0;

    $display("[TB] static pattern table");
    for (int i = 0; i < 5; i++) begin
      writeReg(ADDR_PATTERN, svec[i].data);
      checkOutput("static_ack_high", cfg_ack, 1);
      idle(1);
      checkOutput("static_led", led, svec[i].exp_led);
      checkOutput("static_ack_low", cfg_ack, 0);
    end

    $display("[TB] blink");
    writeReg(ADDR_PATTERN, 16'h000F);
    writeReg(ADDR_PERIOD, 16'd2);
    writeReg(ADDR_MODE, 16'd1);
    observeRuns(60);
    checkOutput("blink_runs", rv.size() >= 4, 1);
    if (rv.size() >= 4) begin
      checkOutput("blink_first", rv[0], 4'hF);
      for (int i = 1; i < 4; i++) begin
        checkOutput("blink_val", rv[i], (i % 2 == 1) ? 4'h0 : 4'hF);
        checkOutput("blink_len", rl[i], 8);
      end
    end
    writeReg(ADDR_PERIOD, 16'd0);
    observeRuns(40);
    checkOutput("blink1_runs", rv.size() >= 4, 1);
    if (rv.size() >= 4) begin
      checkOutput("blink1_first", rv[0], 4'hF);
      for (int i = 1; i < 4; i++) begin
        checkOutput("blink1_val", rv[i], (i % 2 == 1) ? 4'h0 : 4'hF);
        checkOutput("blink1_len", rl[i], 4);
      end
    end

    $display("[TB] scan");
    writeReg(ADDR_PERIOD, 16'd1);
    writeReg(ADDR_MODE, 16'd2);
    observeRuns(40);
    checkOutput("scan_runs", rv.size() >= 8, 1);
    if (rv.size() >= 8) begin
      for (int i = 0; i < 8; i++) checkOutput("scan_seq", rv[i], scan_exp[i]);
      for (int i = 1; i < 7; i++) checkOutput("scan_len", rl[i], 4);
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(1);
      if (led == 4'b1000) found = 1'b1;
    end
    checkOutput("scan_reach_top", found, 1);
    writeReg(ADDR_MODE, 16'd2);
    idle(1);
    checkOutput("scan_restart", led, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      idle(1);
      if (led != 4'b0001) found = 1'b1;
    end
    checkOutput("scan_restart_dir", led, 4'b0010);

    $display("[TB] tick/write collision");
    writeReg(ADDR_PATTERN, 16'h000F);
    writeReg(ADDR_MODE, 16'd1);
    found = 1'b0;
    for (int i = 0; i < 2 * TD && !found; i++) begin
      idle(1);
      if (tick) found = 1'b1;
    end
    checkOutput("collide_tick_seen", found, 1);
    writeReg(ADDR_PERIOD, 16'd2);
    all_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (led != 4'hF) all_on = 1'b0;
    end
    checkOutput("collide_hold_on", all_on, 1);
    idle(1);
    checkOutput("collide_toggle", led, 4'h0);

    $display("[TB] pwm");
    writeReg(ADDR_PATTERN, 16'h0003);
    writeReg(ADDR_DUTY, 16'd64);
    writeReg(ADDR_MODE, 16'd3);
    idle(1);
    hi = 0; upper = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (led[1:0] == 2'b11) hi++;
      if (led[3:2] != 2'b00) upper++;
    end
    checkOutput("pwm64_high", hi, 64);
    checkOutput("pwm64_upper", upper, 0);
    writeReg(ADDR_DUTY, 16'd0);
    idle(1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (led != '0) hi++;
    end
    checkOutput("pwm0_high", hi, 0);
    writeReg(ADDR_DUTY, 16'hFFFF);
    idle(1);
    lo = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (led[1:0] == 2'b00) lo++;
    end
    checkOutput("pwm255_low", lo, 1);

    $display("[TB] async reset mid-cycle");
    writeReg(ADDR_MODE, 16'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_led", led, 0);
    checkOutput("midreset_ack", cfg_ack, 0);
    checkOutput("midreset_tick", tick, 0);
    #1;
    reset = 1'b0;
    modelReset();
    writeReg(ADDR_PATTERN, 16'h0006);
    idle(1);
    checkOutput("post_reset_static", led, 4'b0110);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      logic [1:0] a;
      logic [15:0] d;
      a = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      if (a == ADDR_PERIOD) d = 16'($urandom_range(0, 3));
      writeReg(a, d);
      idle($urandom_range(0, 30));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
